// File: rtl/alu_pkg.sv
// Shared types for the byte-serial 16-bit add sequencer.
package alu_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LO   = 3'd1,
    HI   = 3'd2,
    INC  = 3'd3,
    RESP = 3'd4
  } state_t;

  typedef logic req_id_t;

endpackage

// File: rtl/add16_share_ctrl_if.sv
// Requester and response bundle between the ALU front-end and the add sequencer.
interface add16_share_ctrl_if;
  import alu_pkg::*;

  logic        req0_valid;
  logic        req0_ready;
  logic [15:0] req0_a;
  logic [15:0] req0_b;
  logic        req1_valid;
  logic        req1_ready;
  logic [15:0] req1_a;
  logic [15:0] req1_b;
  logic        resp_valid;
  logic        resp_ready;
  req_id_t     resp_id;
  logic [15:0] resp_sum;
  logic        resp_carry;
  logic        busy;

  modport master (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    output resp_ready,
    input  req0_ready, req1_ready,
    input  resp_valid, resp_id, resp_sum, resp_carry, busy
  );

  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    input  resp_ready,
    output req0_ready, req1_ready,
    output resp_valid, resp_id, resp_sum, resp_carry, busy
  );

endinterface

// File: rtl/csa.sv
// 8-bit carry-select adder, no carry-in: the upper nibble is precomputed for both
// possible nibble carries and selected by the lower nibble's carry.
module csa (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] sum,
  output logic       co
);

  logic [4:0] lo_w;
  logic [4:0] hi0_w;
  logic [4:0] hi1_w;

  always_comb begin
    lo_w  = {1'b0, a[3:0]} + {1'b0, b[3:0]};
    hi0_w = {1'b0, a[7:4]} + {1'b0, b[7:4]};
    hi1_w = {1'b0, a[7:4]} + {1'b0, b[7:4]} + 5'd1;
    sum   = {(lo_w[4] ? hi1_w[3:0] : hi0_w[3:0]), lo_w[3:0]};
    co    = lo_w[4] ? hi1_w[4] : hi0_w[4];
  end

endmodule

// File: rtl/add16_share_ctrl.sv
// Two-requester round-robin sequencer that runs 16-bit adds as byte passes
// through one shared 8-bit adder, returning one tagged result per request.
module add16_share_ctrl
  import alu_pkg::*;
#(
  parameter int PRIO_INIT = 0,
  parameter int SKIP_INC  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  add16_share_ctrl_if.slave   bus
);

  state_t              state_reg, state_next;
  req_id_t             prio_reg;
  req_id_t             id_reg;
  logic [15:0]         a_reg, b_reg;
  logic [BYTE_W-1:0]   sum_lo_reg, t_reg, hi_reg;
  logic                c_lo_reg, ov1_reg, carry_reg;

  logic [BYTE_W-1:0]   add_a, add_b, add_sum;
  logic                add_co;
  logic                any_valid;
  req_id_t             grant;

  csa u_csa (
    .a   (add_a),
    .b   (add_b),
    .sum (add_sum),
    .co  (add_co)
  );

  // Priority only matters on a collision; a lone requester always wins.
  assign any_valid = bus.req0_valid | bus.req1_valid;
  assign grant     = (bus.req0_valid && bus.req1_valid) ? prio_reg : req_id_t'(bus.req1_valid);

  always_comb begin
    state_next     = state_reg;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    add_a          = '0;
    add_b          = '0;
    case (state_reg)
      IDLE: begin
        if (any_valid) begin
          bus.req0_ready = (grant == 1'b0);
          bus.req1_ready = (grant == 1'b1);
          state_next     = LO;
        end
      end
      LO: begin
        add_a      = a_reg[7:0];
        add_b      = b_reg[7:0];
        state_next = HI;
      end
      HI: begin
        add_a      = a_reg[15:8];
        add_b      = b_reg[15:8];
        state_next = (c_lo_reg || SKIP_INC == 0) ? INC : RESP;
      end
      INC: begin
        add_a      = t_reg;
        add_b      = {7'b0, c_lo_reg};
        state_next = RESP;
      end
      RESP: begin
        if (bus.resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      prio_reg   <= req_id_t'(PRIO_INIT != 0);
      id_reg     <= 1'b0;
      a_reg      <= '0;
      b_reg      <= '0;
      sum_lo_reg <= '0;
      c_lo_reg   <= 1'b0;
      t_reg      <= '0;
      ov1_reg    <= 1'b0;
      hi_reg     <= '0;
      carry_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (any_valid) begin
            a_reg    <= grant ? bus.req1_a : bus.req0_a;
            b_reg    <= grant ? bus.req1_b : bus.req0_b;
            id_reg   <= grant;
            prio_reg <= ~grant;
          end
        end
        LO: begin
          sum_lo_reg <= add_sum;
          c_lo_reg   <= add_co;
        end
        HI: begin
          // Result is final here when INC is skipped; INC overwrites it otherwise.
          t_reg     <= add_sum;
          ov1_reg   <= add_co;
          hi_reg    <= add_sum;
          carry_reg <= add_co;
        end
        INC: begin
          hi_reg    <= add_sum;
          carry_reg <= ov1_reg | add_co;
        end
        default: ;
      endcase
    end
  end

  assign bus.resp_valid = (state_reg == RESP);
  assign bus.resp_id    = id_reg;
  assign bus.resp_sum   = {hi_reg, sum_lo_reg};
  assign bus.resp_carry = carry_reg;
  assign bus.busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_add16_share_ctrl.sv
// Directed bench: byte-serial adds, round-robin alternation, response stall,
// mid-operation reset, and the fixed-latency variant.
module tb_add16_share_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  add16_share_ctrl_if if0 ();
  add16_share_ctrl_if if1 ();

  add16_share_ctrl #(.PRIO_INIT(0), .SKIP_INC(1)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0)
  );

  add16_share_ctrl #(.PRIO_INIT(0), .SKIP_INC(0)) u_dut_noskip (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One request on if0 with resp_ready held high; latency counts the accept edge as 1.
  task automatic run_one(input logic rid, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] es, input logic ec, input int elat);
    int n;
    int lat;
    if0.resp_ready = 1'b1;
    if (rid) begin
      if0.req1_valid = 1'b1; if0.req1_a = a; if0.req1_b = b;
    end else begin
      if0.req0_valid = 1'b1; if0.req0_a = a; if0.req0_b = b;
    end
    #1;
    n = 0;
    while (!(rid ? if0.req1_ready : if0.req0_ready) && n < 10) begin
      @(posedge clk); #1; n++;
    end
    check("ready", 32'(rid ? if0.req1_ready : if0.req0_ready), 32'd1);
    @(posedge clk); #1;
    if0.req0_valid = 1'b0;
    if0.req1_valid = 1'b0;
    check("busy_after_accept", 32'(if0.busy), 32'd1);
    lat = 1;
    while (!if0.resp_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    $display("txn id=%0d a=%h b=%h sum=%h carry=%b resp_id=%0d latency=%0d",
             rid, a, b, if0.resp_sum, if0.resp_carry, if0.resp_id, lat);
    check("latency", 32'(lat), 32'(elat));
    check("resp_valid", 32'(if0.resp_valid), 32'd1);
    check("resp_sum", 32'(if0.resp_sum), 32'(es));
    check("resp_carry", 32'(if0.resp_carry), 32'(ec));
    check("resp_id", 32'(if0.resp_id), 32'(rid));
    @(posedge clk); #1;
    check("resp_drop", 32'(if0.resp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    if0.req0_valid = 1'b0; if0.req0_a = '0; if0.req0_b = '0;
    if0.req1_valid = 1'b0; if0.req1_a = '0; if0.req1_b = '0;
    if0.resp_ready = 1'b0;
    if1.req0_valid = 1'b0; if1.req0_a = '0; if1.req0_b = '0;
    if1.req1_valid = 1'b0; if1.req1_a = '0; if1.req1_b = '0;
    if1.resp_ready = 1'b0;
    #1;
    check("rst_resp_valid", 32'(if0.resp_valid), 32'd0);
    check("rst_busy", 32'(if0.busy), 32'd0);
    check("rst_sum", 32'(if0.resp_sum), 32'd0);
    check("rst_carry", 32'(if0.resp_carry), 32'd0);
    check("rst_id", 32'(if0.resp_id), 32'd0);
    check("rst_ready0", 32'(if0.req0_ready), 32'd0);
    check("rst_ready1", 32'(if0.req1_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic vectors: no carry, carry through INC, wrap, and bit-15 overflow without INC
    run_one(1'b0, 16'h1234, 16'h0101, 16'h1335, 1'b0, 3);
    run_one(1'b1, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 4);
    run_one(1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 4);
    run_one(1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 3);

    // Round-robin alternation from a fresh reset with both requesters always valid
    rst_n = 1'b0; #1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    if0.req0_valid = 1'b1; if0.req0_a = 16'h0011; if0.req0_b = 16'h0022;
    if0.req1_valid = 1'b1; if0.req1_a = 16'h0100; if0.req1_b = 16'h0200;
    if0.resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!if0.resp_valid && n < 20) begin
        @(posedge clk); #1; n++;
      end
      $display("txn alternate idx=%0d resp_id=%0d sum=%h", i, if0.resp_id, if0.resp_sum);
      check("alt_valid", 32'(if0.resp_valid), 32'd1);
      check("alt_id", 32'(if0.resp_id), 32'(i % 2));
      check("alt_sum", 32'(if0.resp_sum), (i % 2 == 0) ? 32'h0033 : 32'h0300);
      @(posedge clk); #1;
      if (i == 3) begin
        if0.req0_valid = 1'b0;
        if0.req1_valid = 1'b0;
      end
    end
    @(posedge clk); #1;
    check("alt_idle", 32'(if0.busy), 32'd0);

    // Response stall: outputs hold, no ready while a result waits
    if0.resp_ready = 1'b0;
    if0.req0_valid = 1'b1; if0.req0_a = 16'h00FF; if0.req0_b = 16'h0001;
    #1;
    check("stall_ready0", 32'(if0.req0_ready), 32'd1);
    @(posedge clk); #1;
    if0.req0_valid = 1'b0;
    if0.req1_valid = 1'b1; if0.req1_a = 16'h5555; if0.req1_b = 16'h1111;
    n = 0;
    while (!if0.resp_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 32'(if0.resp_valid), 32'd1);
      check("stall_sum", 32'(if0.resp_sum), 32'h0100);
      check("stall_carry", 32'(if0.resp_carry), 32'd0);
      check("stall_id", 32'(if0.resp_id), 32'd0);
      check("stall_ready0", 32'(if0.req0_ready), 32'd0);
      check("stall_ready1", 32'(if0.req1_ready), 32'd0);
      @(posedge clk); #1;
    end
    $display("txn stall id=%0d sum=%h carry=%b", if0.resp_id, if0.resp_sum, if0.resp_carry);
    if0.req1_valid = 1'b0;
    if0.resp_ready = 1'b1;
    @(posedge clk); #1;
    check("stall_release_valid", 32'(if0.resp_valid), 32'd0);
    check("stall_release_busy", 32'(if0.busy), 32'd0);

    // Asynchronous reset while in HI drops the request
    if0.req0_valid = 1'b1; if0.req0_a = 16'h1234; if0.req0_b = 16'h0101;
    @(posedge clk); #1;
    if0.req0_valid = 1'b0;
    @(posedge clk); #1;
    check("hi_busy", 32'(if0.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(if0.busy), 32'd0);
    check("arst_valid", 32'(if0.resp_valid), 32'd0);
    check("arst_sum", 32'(if0.resp_sum), 32'd0);
    check("arst_carry", 32'(if0.resp_carry), 32'd0);
    check("arst_id", 32'(if0.resp_id), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      check("arst_no_resp", 32'(if0.resp_valid), 32'd0);
    end
    $display("txn reset_during_hi dropped");
    run_one(1'b1, 16'hABCD, 16'h1111, 16'hBCDE, 1'b0, 4 - 1);

    // Fixed-latency variant always runs INC
    begin
      int lat;
      if1.resp_ready = 1'b1;
      if1.req0_valid = 1'b1; if1.req0_a = 16'h1234; if1.req0_b = 16'h0101;
      #1;
      check("noskip_ready", 32'(if1.req0_ready), 32'd1);
      @(posedge clk); #1;
      if1.req0_valid = 1'b0;
      lat = 1;
      while (!if1.resp_valid && lat < 20) begin
        @(posedge clk); #1; lat++;
      end
      $display("txn noskip id=%0d sum=%h carry=%b latency=%0d",
               if1.resp_id, if1.resp_sum, if1.resp_carry, lat);
      check("noskip_latency", 32'(lat), 32'd4);
      check("noskip_sum", 32'(if1.resp_sum), 32'h1335);
      check("noskip_carry", 32'(if1.resp_carry), 32'd0);
      check("noskip_id", 32'(if1.resp_id), 32'd0);
      @(posedge clk); #1;
      check("noskip_drop", 32'(if1.resp_valid), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
